// File: rtl/simulation_top_core_if.sv
// AXI-Stream C2H beat channel between the traffic source and the DMA sink.
// The master drives data/keep/valid/last and the sink answers with ready.
interface simulation_top_core_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/simulation_top_core.sv
// Simulated C2H traffic source: a divided core clock, a trigger-built packet
// and a first-word-fall-through beat FIFO drained over AXI-Stream.
module simulation_top_core #(
  parameter int CORE_DIV   = 1,
  parameter int PKT_BEATS  = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_en,
  input  logic                        io_enable,
  output logic                        core_clk,
  simulation_top_core_if.master       m_axis_c2h,
  output logic [31:0]                 pkt_cnt,
  output logic [15:0]                 drop_cnt
);

  localparam int DW = (CORE_DIV > 1) ? $clog2(CORE_DIV) : 1;
  localparam int IW = $clog2(PKT_BEATS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_TC = DW'(CORE_DIV - 1);
  localparam logic [IW-1:0] LAST   = IW'(PKT_BEATS - 1);
  localparam logic [AW:0]   LIMIT  = (AW + 1)'(FIFO_DEPTH - PKT_BEATS);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] div_q;
  logic [31:0]   cycle_q;
  logic          en_q;
  logic          en_qq;
  logic          trig;
  logic [15:0]   seq_q;
  logic [31:0]   cyc_q;
  logic [IW-1:0] idx_q;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   used;
  logic          room;
  logic          push;
  logic          pop;
  logic          accept;
  logic          drop;
  logic          last_beat;
  logic [64:0]   wbeat;
  logic [64:0]   head;
  logic [64:0]   mem [FIFO_DEPTH];

  assign trig      = en_q & ~en_qq;
  assign used      = wr_ptr - rd_ptr;
  assign room      = used <= LIMIT;
  assign last_beat = (state_q == WRITE) && (idx_q == LAST);
  assign pop       = m_axis_c2h.tvalid & m_axis_c2h.tready;
  assign head      = mem[rd_ptr[AW-1:0]];

  assign m_axis_c2h.tkeep  = 8'hFF;
  assign m_axis_c2h.tvalid = |used;
  assign m_axis_c2h.tdata  = m_axis_c2h.tvalid ? head[63:0] : 64'd0;
  assign m_axis_c2h.tlast  = m_axis_c2h.tvalid & head[64];

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    accept  = 1'b0;
    drop    = 1'b0;
    wbeat   = {1'b0, 16'hA55A, seq_q, cycle_q};
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          if (room) begin
            accept  = 1'b1;
            push    = 1'b1;
            state_d = WRITE;
          end else begin
            drop = 1'b1;
          end
        end
      end
      WRITE: begin
        push  = 1'b1;
        drop  = trig;
        wbeat = {last_beat, 16'(idx_q), seq_q, cyc_q + 32'(idx_q)};
        if (idx_q == LAST) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_en) begin
    if (rst_en) begin
      div_q    <= '0;
      core_clk <= 1'b0;
      cycle_q  <= '0;
      en_q     <= 1'b0;
      en_qq    <= 1'b0;
      state_q  <= IDLE;
      seq_q    <= '0;
      cyc_q    <= '0;
      idx_q    <= '0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (div_q == DIV_TC) begin
        div_q    <= '0;
        core_clk <= ~core_clk;
        if (!core_clk) cycle_q <= cycle_q + 32'd1;
      end else begin
        div_q <= div_q + DW'(1);
      end
      en_q    <= io_enable;
      en_qq   <= en_q;
      state_q <= state_d;
      if (accept) begin
        cyc_q <= cycle_q;
        idx_q <= IW'(1);
      end else if (state_q == WRITE) begin
        idx_q <= idx_q + IW'(1);
      end
      if (last_beat) begin
        seq_q   <= seq_q + 16'd1;
        pkt_cnt <= pkt_cnt + 32'd1;
      end
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  // Storage needs no reset: occupancy comes only from the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wbeat;
  end

endmodule

// File: tb/tb_simulation_top_core.sv
// Randomised bench for the C2H traffic source against a packet-level model.
// The model predicts beats, counters, core clock and stream occupancy.
module tb_simulation_top_core;

  localparam int DIV   = 1;
  localparam int PB    = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic        last;
    logic [63:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_en = 1'b1;
  logic        io_enable = 1'b0;
  logic        core_clk;
  logic [31:0] pkt_cnt;
  logic [15:0] drop_cnt;

  simulation_top_core_if axis ();

  simulation_top_core #(
    .CORE_DIV  (DIV),
    .PKT_BEATS (PB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst_en    (rst_en),
    .io_enable (io_enable),
    .core_clk  (core_clk),
    .m_axis_c2h(axis),
    .pkt_cnt   (pkt_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  beat_t       expq[$];
  int          occ;
  int          rem;
  int          n;
  int unsigned mpkt;
  int unsigned mdrop;
  bit          q1;
  bit          q2;
  bit          drv_en;
  bit          pend_pop;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    expq.delete();
    occ = 0;
    rem = 0;
    n = 0;
    mpkt = 0;
    mdrop = 0;
    q1 = 0;
    q2 = 0;
    drv_en = 0;
    pend_pop = 0;
  endtask

  // One clk period: account for the posedge just passed, drive, then check.
  task automatic cyc(input bit en, input bit rdy);
    bit          trig;
    logic [31:0] cycv;
    logic [15:0] seq;
    beat_t       b;
    @(negedge clk);
    if (rst_en) begin
      model_reset();
    end else begin
      n++;
      trig = q1 && !q2;
      cycv = 32'((((n - 1) / DIV) + 1) / 2);
      if (rem > 0) begin
        occ++;
        rem--;
        if (rem == 0) mpkt++;
        if (trig && mdrop < 65535) mdrop++;
      end else if (trig) begin
        if (occ <= DEPTH - PB) begin
          seq = mpkt[15:0];
          for (int k = 0; k < PB; k++) begin
            b.last = (k == PB - 1);
            if (k == 0) b.data = {16'hA55A, seq, cycv};
            else        b.data = {16'(k), seq, cycv + 32'(k)};
            expq.push_back(b);
          end
          occ++;
          rem = PB - 1;
        end else if (mdrop < 65535) begin
          mdrop++;
        end
      end
      if (pend_pop) begin
        occ--;
        void'(expq.pop_front());
      end
      q2 = q1;
      q1 = drv_en;
    end
    drv_en = en;
    io_enable = en;
    axis.tready = rdy;
    chk("tvalid", 64'(axis.tvalid), 64'(occ > 0));
    if (occ > 0) begin
      chk("tdata", axis.tdata, expq[0].data);
      chk("tlast", 64'(axis.tlast), 64'(expq[0].last));
    end
    chk("pkt_cnt", 64'(pkt_cnt), 64'(mpkt));
    chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
    chk("core_clk", 64'(core_clk), 64'((n / DIV) % 2));
    pend_pop = (occ > 0) && rdy;
  endtask

  initial begin
    bit en_r;
    model_reset();
    axis.tready = 1'b0;
    repeat (10) cyc(0, 0);
    rst_en = 1'b0;
    chk("rst_tdata", axis.tdata, 64'd0);
    chk("tkeep", 64'(axis.tkeep), 64'hFF);

    for (int p = 0; p < 6; p++) begin
      repeat (4) cyc(1, 1);
      repeat (28) cyc(0, 1);
    end
    chk("t1_pkts", 64'(pkt_cnt), 64'd6);
    chk("t1_drops", 64'(drop_cnt), 64'd0);

    for (int p = 0; p < 6; p++) begin
      repeat (2) cyc(1, 0);
      repeat (30) cyc(0, 0);
    end
    chk("t3_full", 64'(axis.tvalid), 64'd1);
    chk("t3_drops", 64'(drop_cnt), 64'd2);
    chk("t3_pkts", 64'(pkt_cnt), 64'd10);
    repeat (40) cyc(0, 1);
    chk("t3_drained", 64'(axis.tvalid), 64'd0);

    repeat (100) cyc(1, 1);
    repeat (10) cyc(0, 1);
    chk("t4_held", 64'(pkt_cnt), 64'd11);
    cyc(1, 1);
    cyc(0, 1);
    cyc(1, 1);
    repeat (20) cyc(0, 1);
    chk("t4_pkts", 64'(pkt_cnt), 64'd12);
    chk("t4_drops", 64'(drop_cnt), 64'd3);

    en_r = 0;
    repeat (800) begin
      if ($urandom_range(0, 7) == 0) en_r = !en_r;
      cyc(en_r, 1'($urandom_range(0, 1)));
    end
    repeat (60) cyc(0, 1);

    cyc(1, 0);
    repeat (3) cyc(0, 0);
    chk("t6_pre", 64'(axis.tvalid), 64'd1);
    rst_en = 1'b1;
    #1;
    chk("t6_tvalid", 64'(axis.tvalid), 64'd0);
    chk("t6_tdata", axis.tdata, 64'd0);
    chk("t6_pkts", 64'(pkt_cnt), 64'd0);
    chk("t6_drops", 64'(drop_cnt), 64'd0);
    repeat (3) cyc(0, 1);
    rst_en = 1'b0;
    cyc(1, 1);
    repeat (20) cyc(0, 1);
    chk("t6_after", 64'(pkt_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
